// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32 opcodes, func7 codes and the control
// bundle carried from decode into execute.
package decode_pkg;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] LUI    = 7'b0110111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   localparam logic [4:0] ALU_NONE = 5'b00000;

   typedef struct packed {
      logic [4:0] alu_op;
      logic       alu_in_b;
      logic       is_branch;
      logic       is_jal;
      logic       is_jalr;
      logic       is_auipc;
      logic       is_lui;
      logic       is_load;
      logic       is_store;
      logic       illegal;
      logic       rwe;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } ctrl_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I(+M) decoder: instruction word to control
// bundle, sign-extended immediate and source-register usage.
module decode_comb
   import decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter bit EN_M = 1'b0
) (
   input  logic [31:0]     instr,
   output ctrl_t           ctrl,
   output logic [XLEN-1:0] imm,
   output logic            uses_rs1,
   output logic            uses_rs2
);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rd_f;
   logic        f7_ok;
   logic        wr;
   logic [31:0] imm32;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;

   assign opc  = instr[6:0];
   assign f3   = instr[14:12];
   assign f7   = instr[31:25];
   assign rd_f = instr[11:7];

   assign f7_ok = (f7 == F7_BASE) | (f7 == F7_ALT)
                | (EN_M & (f7 == F7_MUL));

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};

   assign imm = XLEN'(signed'(imm32));

   // Opcode decode; anything unrecognised leaves the bundle cleared but illegal.
   always_comb begin
      ctrl     = '0;
      imm32    = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      wr       = 1'b0;
      ctrl.rd  = rd_f;
      ctrl.rs1 = instr[19:15];
      ctrl.rs2 = instr[24:20];
      unique case (opc)
         OP: begin
            if (f7_ok) begin
               ctrl.alu_op = {f7 == F7_MUL, f7[5], f3};
               uses_rs1    = 1'b1;
               uses_rs2    = 1'b1;
               wr          = 1'b1;
            end else begin
               ctrl.illegal = 1'b1;
            end
         end
         OP_IMM: begin
            ctrl.alu_op   = {1'b0, (f3 == 3'b101) & f7[5], f3};
            ctrl.alu_in_b = 1'b1;
            imm32         = imm_i;
            uses_rs1      = 1'b1;
            wr            = 1'b1;
         end
         LOAD: begin
            ctrl.is_load  = 1'b1;
            ctrl.alu_in_b = 1'b1;
            imm32         = imm_i;
            uses_rs1      = 1'b1;
            wr            = 1'b1;
         end
         STORE: begin
            ctrl.is_store = 1'b1;
            ctrl.alu_in_b = 1'b1;
            imm32         = imm_s;
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
         end
         BRANCH: begin
            ctrl.is_branch = 1'b1;
            ctrl.alu_op    = {2'b00, f3};
            imm32          = imm_b;
            uses_rs1       = 1'b1;
            uses_rs2       = 1'b1;
         end
         JAL: begin
            ctrl.is_jal = 1'b1;
            imm32       = imm_j;
            wr          = 1'b1;
         end
         JALR: begin
            ctrl.is_jalr  = 1'b1;
            ctrl.alu_in_b = 1'b1;
            imm32         = imm_i;
            uses_rs1      = 1'b1;
            wr            = 1'b1;
         end
         AUIPC: begin
            ctrl.is_auipc = 1'b1;
            ctrl.alu_in_b = 1'b1;
            imm32         = imm_u;
            wr            = 1'b1;
         end
         LUI: begin
            ctrl.is_lui   = 1'b1;
            ctrl.alu_in_b = 1'b1;
            imm32         = imm_u;
            wr            = 1'b1;
         end
         default: begin
            ctrl.illegal = 1'b1;
         end
      endcase
      ctrl.rwe = wr & (rd_f != 5'd0);
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: ID/EX register with valid/ready handshake,
// load-use bubble insertion and flush.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter bit EN_M = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc_in,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      alu_op,
   output logic            alu_in_b,
   output logic            is_branch,
   output logic            is_jal,
   output logic            is_jalr,
   output logic            is_auipc,
   output logic            is_lui,
   output logic            is_load,
   output logic            is_store,
   output logic            illegal,
   output logic            rwe,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] pc_out
);

   ctrl_t           dec;
   logic [XLEN-1:0] dec_imm;
   logic            uses_rs1;
   logic            uses_rs2;

   ctrl_t           ctrl_q, ctrl_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic            lu_valid_q, lu_valid_d;
   logic [4:0]      lu_rd_q, lu_rd_d;

   logic            hazard;
   logic            accept;
   logic            bubble;

   decode_comb #(
      .XLEN (XLEN),
      .EN_M (EN_M)
   ) u_comb (
      .instr    (instr),
      .ctrl     (dec),
      .imm      (dec_imm),
      .uses_rs1 (uses_rs1),
      .uses_rs2 (uses_rs2)
   );

   assign hazard = in_valid & lu_valid_q
                 & ((uses_rs1 & (dec.rs1 == lu_rd_q))
                 |  (uses_rs2 & (dec.rs2 == lu_rd_q)));

   assign in_ready = ~reset & ~hazard & (~valid_q | out_ready);
   assign accept   = in_valid & in_ready & ~flush;
   assign bubble   = hazard & (~valid_q | out_ready);

   // Next state: flush beats accept, accept beats bubble, else drain.
   always_comb begin
      ctrl_d     = ctrl_q;
      imm_d      = imm_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      lu_valid_d = lu_valid_q;
      lu_rd_d    = lu_rd_q;
      if (flush) begin
         valid_d    = 1'b0;
         lu_valid_d = 1'b0;
      end else if (accept) begin
         ctrl_d     = dec;
         imm_d      = dec_imm;
         pc_d       = pc_in;
         valid_d    = 1'b1;
         lu_valid_d = dec.is_load & (dec.rd != 5'd0);
         lu_rd_d    = dec.rd;
      end else if (bubble) begin
         valid_d    = 1'b0;
         lu_valid_d = 1'b0;
      end else if (out_ready) begin
         valid_d    = 1'b0;
      end
   end

   // ID/EX register and load-use tracker.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q     <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         valid_q    <= 1'b0;
         lu_valid_q <= 1'b0;
         lu_rd_q    <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         imm_q      <= imm_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         lu_valid_q <= lu_valid_d;
         lu_rd_q    <= lu_rd_d;
      end
   end

   assign out_valid = valid_q;
   assign alu_op    = ctrl_q.alu_op;
   assign alu_in_b  = ctrl_q.alu_in_b;
   assign is_branch = ctrl_q.is_branch;
   assign is_jal    = ctrl_q.is_jal;
   assign is_jalr   = ctrl_q.is_jalr;
   assign is_auipc  = ctrl_q.is_auipc;
   assign is_lui    = ctrl_q.is_lui;
   assign is_load   = ctrl_q.is_load;
   assign is_store  = ctrl_q.is_store;
   assign illegal   = ctrl_q.illegal;
   assign rwe       = ctrl_q.rwe;
   assign rd        = ctrl_q.rd;
   assign rs1       = ctrl_q.rs1;
   assign rs2       = ctrl_q.rs2;
   assign imm       = imm_q;
   assign pc_out    = pc_q;

endmodule
